// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU tile controller.
// Holds the controller state encoding, the default array geometry and a
// small ceiling-division helper used for tile counts.
package tpu_pkg;

  localparam int SA_DIM_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } tile_state_t;

  // ceil(num/den) for an 8-bit dimension; den is the array edge (>= 2).
  function automatic logic [7:0] ceil_div8(input logic [7:0] num, input int unsigned den);
    logic [15:0] sum;
    sum = 16'(num) + 16'(den) - 16'd1;
    return 8'(sum / 16'(den));
  endfunction

endpackage

// File: rtl/tpu_tile_ctrl_if.sv
// Global-buffer bus of the tile controller.
// master: controller side (drives read indices and C writes, receives read data).
// slave : buffer side (returns A/B words one cycle after the index, accepts C writes).
interface tpu_tile_ctrl_if #(
  parameter int SA_DIM = tpu_pkg::SA_DIM_DEF,
  parameter int DATA_W = tpu_pkg::DATA_W_DEF,
  parameter int ACC_W  = tpu_pkg::ACC_W_DEF,
  parameter int ADDR_W = 16
) ();

  logic [ADDR_W-1:0]        A_index;
  logic [ADDR_W-1:0]        B_index;
  logic [SA_DIM*DATA_W-1:0] A_data_out;
  logic [SA_DIM*DATA_W-1:0] B_data_out;
  logic                     C_wr_en;
  logic [ADDR_W-1:0]        C_index;
  logic [SA_DIM*ACC_W-1:0]  C_data_in;

  modport master (
    output A_index, B_index, C_wr_en, C_index, C_data_in,
    input  A_data_out, B_data_out
  );

  modport slave (
    input  A_index, B_index, C_wr_en, C_index, C_data_in,
    output A_data_out, B_data_out
  );

endinterface

// File: rtl/tpu_skew_buf.sv
// Per-lane delay line that skews operands into the systolic array.
// Lane i is delayed by i cycles; lane 0 passes straight through.
// Ports: clk, rst_n (async active-low), din (LANES packed words), dout (skewed words).
module tpu_skew_buf #(
  parameter int LANES  = tpu_pkg::SA_DIM_DEF,
  parameter int DATA_W = tpu_pkg::DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*DATA_W-1:0] din,
  output logic [LANES*DATA_W-1:0] dout
);

  assign dout[DATA_W-1:0] = din[DATA_W-1:0];

  for (genvar i = 1; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] pipe_r [i];

    // Shift register giving lane i a delay of exactly i cycles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d < i; d++) pipe_r[d] <= '0;
      end else begin
        pipe_r[0] <= din[i*DATA_W +: DATA_W];
        for (int d = 1; d < i; d++) pipe_r[d] <= pipe_r[d-1];
      end
    end

    assign dout[i*DATA_W +: DATA_W] = pipe_r[i-1];
  end

endmodule

// File: rtl/tpu_tile_ctrl.sv
// Tile controller for an SA_DIM x SA_DIM output-stationary systolic array.
// Splits C = A*B (M x K times K x N) into SA_DIM-square output tiles, visited
// mt-major, and for each tile clears the array, streams K operand words with
// skew, flushes for 2*SA_DIM cycles and writes back the valid result rows.
// Ports: clk/rst_n; in_valid + K/M/N start a job; busy/done status;
// A/B read bus (1-cycle latency); C write bus; sa_* drive/observe the array.
module tpu_tile_ctrl
  import tpu_pkg::*;
#(
  parameter int SA_DIM = SA_DIM_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [7:0]                     K,
  input  logic [7:0]                     M,
  input  logic [7:0]                     N,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_W-1:0]              A_index,
  output logic [ADDR_W-1:0]              B_index,
  input  logic [SA_DIM*DATA_W-1:0]       A_data_out,
  input  logic [SA_DIM*DATA_W-1:0]       B_data_out,
  output logic                           C_wr_en,
  output logic [ADDR_W-1:0]              C_index,
  output logic [SA_DIM*ACC_W-1:0]        C_data_in,
  output logic                           sa_clear,
  output logic [SA_DIM*DATA_W-1:0]       sa_west,
  output logic [SA_DIM*DATA_W-1:0]       sa_north,
  input  logic [SA_DIM*SA_DIM*ACC_W-1:0] sa_result
);

  tile_state_t state_r, state_s;
  logic [7:0] k_len_r, k_len_s, m_len_r, m_len_s, n_len_r, n_len_s;
  logic [7:0] mt_tot_r, mt_tot_s, nt_tot_r, nt_tot_s;
  logic [7:0] mt_r, mt_s, nt_r, nt_s;
  logic [7:0] k_cnt_r, k_cnt_s, flush_r, flush_s, row_r, row_s;
  logic [15:0] rem_rows_s;
  logic [7:0]  row_last_s;
  logic        feed_d1_r;

  logic                      busy_r, busy_s, done_r, done_s;
  logic                      clear_r, clear_s, wr_en_r, wr_en_s;
  logic [ADDR_W-1:0]         a_index_r, a_index_s, b_index_r, b_index_s;
  logic [ADDR_W-1:0]         c_index_r, c_index_s;
  logic [SA_DIM*ACC_W-1:0]   c_data_r, c_data_s;
  logic [SA_DIM*DATA_W-1:0]  west_in_s, north_in_s;

  // Last valid row index of the current tile row band (partial band at the M edge).
  always_comb begin
    rem_rows_s = 16'(m_len_r) - 16'(mt_r) * 16'(SA_DIM);
    if (rem_rows_s >= 16'(SA_DIM)) begin
      row_last_s = 8'(SA_DIM - 1);
    end else begin
      row_last_s = 8'(rem_rows_s - 16'd1);
    end
  end

  // Next-state and counter logic of the tile sequencer.
  always_comb begin
    state_s  = state_r;
    k_len_s  = k_len_r;
    m_len_s  = m_len_r;
    n_len_s  = n_len_r;
    mt_tot_s = mt_tot_r;
    nt_tot_s = nt_tot_r;
    mt_s     = mt_r;
    nt_s     = nt_r;
    k_cnt_s  = k_cnt_r;
    flush_s  = flush_r;
    row_s    = row_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          k_len_s  = K;
          m_len_s  = M;
          n_len_s  = N;
          mt_tot_s = ceil_div8(M, SA_DIM);
          nt_tot_s = ceil_div8(N, SA_DIM);
          mt_s     = 8'd0;
          nt_s     = 8'd0;
          k_cnt_s  = 8'd0;
          flush_s  = 8'd0;
          row_s    = 8'd0;
          // An empty product finishes immediately without touching C.
          if ((K == 8'd0) || (M == 8'd0) || (N == 8'd0)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_CLEAR;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_s = ST_FEED;
        k_cnt_s = 8'd0;
      end
      ST_FEED: begin
        if (k_cnt_r == k_len_r - 8'd1) begin
          state_s = ST_FLUSH;
          flush_s = 8'd0;
        end else begin
          k_cnt_s = k_cnt_r + 8'd1;
        end
      end
      ST_FLUSH: begin
        if (flush_r == 8'(2 * SA_DIM - 1)) begin
          state_s = ST_WRITE;
          row_s   = 8'd0;
        end else begin
          flush_s = flush_r + 8'd1;
        end
      end
      ST_WRITE: begin
        if (row_r == row_last_s) begin
          if (nt_r == nt_tot_r - 8'd1) begin
            if (mt_r == mt_tot_r - 8'd1) begin
              state_s = ST_DONE;
            end else begin
              mt_s    = mt_r + 8'd1;
              nt_s    = 8'd0;
              state_s = ST_CLEAR;
            end
          end else begin
            nt_s    = nt_r + 8'd1;
            state_s = ST_CLEAR;
          end
        end else begin
          row_s = row_r + 8'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so that
  // every output can be registered yet line up with its state.
  always_comb begin
    busy_s    = (state_s != ST_IDLE);
    done_s    = (state_s == ST_DONE);
    clear_s   = (state_s == ST_CLEAR);
    wr_en_s   = (state_s == ST_WRITE);
    a_index_s = '0;
    b_index_s = '0;
    c_index_s = '0;
    c_data_s  = '0;
    if (state_s == ST_FEED) begin
      a_index_s = ADDR_W'(mt_s) * ADDR_W'(k_len_s) + ADDR_W'(k_cnt_s);
      b_index_s = ADDR_W'(nt_s) * ADDR_W'(k_len_s) + ADDR_W'(k_cnt_s);
    end else begin
      a_index_s = '0;
      b_index_s = '0;
    end
    if (state_s == ST_WRITE) begin
      c_index_s = (ADDR_W'(mt_s) * ADDR_W'(SA_DIM) + ADDR_W'(row_s)) * ADDR_W'(nt_tot_s)
                  + ADDR_W'(nt_s);
      for (int j = 0; j < SA_DIM; j++) begin
        if (16'(nt_s) * 16'(SA_DIM) + 16'(j) < 16'(n_len_s)) begin
          c_data_s[j*ACC_W +: ACC_W] = sa_result[(int'(row_s) * SA_DIM + j) * ACC_W +: ACC_W];
        end else begin
          c_data_s[j*ACC_W +: ACC_W] = '0;
        end
      end
    end else begin
      c_index_s = '0;
      c_data_s  = '0;
    end
  end

  // Operand lanes entering the skew stage: only words returned for a FEED
  // read, and only lanes that map inside the matrix edges.
  always_comb begin
    west_in_s  = '0;
    north_in_s = '0;
    for (int i = 0; i < SA_DIM; i++) begin
      if (feed_d1_r && (16'(mt_r) * 16'(SA_DIM) + 16'(i) < 16'(m_len_r))) begin
        west_in_s[i*DATA_W +: DATA_W] = A_data_out[i*DATA_W +: DATA_W];
      end else begin
        west_in_s[i*DATA_W +: DATA_W] = '0;
      end
      if (feed_d1_r && (16'(nt_r) * 16'(SA_DIM) + 16'(i) < 16'(n_len_r))) begin
        north_in_s[i*DATA_W +: DATA_W] = B_data_out[i*DATA_W +: DATA_W];
      end else begin
        north_in_s[i*DATA_W +: DATA_W] = '0;
      end
    end
  end

  // State, counters, read-return tracking and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      k_len_r   <= 8'd0;
      m_len_r   <= 8'd0;
      n_len_r   <= 8'd0;
      mt_tot_r  <= 8'd0;
      nt_tot_r  <= 8'd0;
      mt_r      <= 8'd0;
      nt_r      <= 8'd0;
      k_cnt_r   <= 8'd0;
      flush_r   <= 8'd0;
      row_r     <= 8'd0;
      feed_d1_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      clear_r   <= 1'b0;
      wr_en_r   <= 1'b0;
      a_index_r <= '0;
      b_index_r <= '0;
      c_index_r <= '0;
      c_data_r  <= '0;
    end else begin
      state_r   <= state_s;
      k_len_r   <= k_len_s;
      m_len_r   <= m_len_s;
      n_len_r   <= n_len_s;
      mt_tot_r  <= mt_tot_s;
      nt_tot_r  <= nt_tot_s;
      mt_r      <= mt_s;
      nt_r      <= nt_s;
      k_cnt_r   <= k_cnt_s;
      flush_r   <= flush_s;
      row_r     <= row_s;
      feed_d1_r <= (state_r == ST_FEED);
      busy_r    <= busy_s;
      done_r    <= done_s;
      clear_r   <= clear_s;
      wr_en_r   <= wr_en_s;
      a_index_r <= a_index_s;
      b_index_r <= b_index_s;
      c_index_r <= c_index_s;
      c_data_r  <= c_data_s;
    end
  end

  tpu_skew_buf #(.LANES(SA_DIM), .DATA_W(DATA_W)) u_west_skew (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (west_in_s),
    .dout (sa_west)
  );

  tpu_skew_buf #(.LANES(SA_DIM), .DATA_W(DATA_W)) u_north_skew (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (north_in_s),
    .dout (sa_north)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign sa_clear  = clear_r;
  assign C_wr_en   = wr_en_r;
  assign A_index   = a_index_r;
  assign B_index   = b_index_r;
  assign C_index   = c_index_r;
  assign C_data_in = c_data_r;

endmodule

// File: tb/tb_tpu_tile_ctrl.sv
// Self-checking bench for tpu_tile_ctrl: synchronous A/B buffer model,
// behavioural output-stationary array, and a scoreboard of expected C writes
// computed directly from the operand matrices.
module tb_tpu_tile_ctrl;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int IW = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [7:0]       K, M, N;
  logic             busy, done, sa_clear;
  logic [S*DW-1:0]  sa_west, sa_north;
  logic [S*S*AW-1:0] sa_result;

  tpu_tile_ctrl_if #(.SA_DIM(S), .DATA_W(DW), .ACC_W(AW), .ADDR_W(IW)) bus ();

  tpu_tile_ctrl #(.SA_DIM(S), .DATA_W(DW), .ACC_W(AW), .ADDR_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .K         (K),
    .M         (M),
    .N         (N),
    .busy      (busy),
    .done      (done),
    .A_index   (bus.A_index),
    .B_index   (bus.B_index),
    .A_data_out(bus.A_data_out),
    .B_data_out(bus.B_data_out),
    .C_wr_en   (bus.C_wr_en),
    .C_index   (bus.C_index),
    .C_data_in (bus.C_data_in),
    .sa_clear  (sa_clear),
    .sa_west   (sa_west),
    .sa_north  (sa_north),
    .sa_result (sa_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- buffer model (1-cycle read latency) ----------------
  logic [S*DW-1:0] a_mem [0:255];
  logic [S*DW-1:0] b_mem [0:255];

  always @(posedge clk) begin
    bus.A_data_out <= a_mem[bus.A_index[7:0]];
    bus.B_data_out <= b_mem[bus.B_index[7:0]];
  end

  // ---------------- behavioural systolic array ----------------
  logic [AW-1:0] acc [S][S];
  logic [DW-1:0] pa  [S][S];
  logic [DW-1:0] pb  [S][S];

  function automatic logic [DW-1:0] w_in(int i, int j);
    if (j == 0) return sa_west[i*DW +: DW];
    else return pa[i][j-1];
  endfunction

  function automatic logic [DW-1:0] n_in(int i, int j);
    if (i == 0) return sa_north[j*DW +: DW];
    else return pb[i-1][j];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) begin
        if (!rst_n || sa_clear) begin
          acc[i][j] <= '0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + AW'(w_in(i, j)) * AW'(n_in(i, j));
          pa[i][j]  <= w_in(i, j);
          pb[i][j]  <= n_in(i, j);
        end
      end
    end
  end

  always_comb begin
    sa_result = '0;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        sa_result[(i*S+j)*AW +: AW] = acc[i][j];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [IW-1:0]   idx;
    logic [S*AW-1:0] data;
  } wr_t;
  wr_t sb_q[$];

  int wr_cnt      = 0;
  int last_wr_cyc = 0;

  always @(negedge clk) begin
    if (bus.C_wr_en === 1'b1) begin : pop_blk
      wr_t e;
      wr_cnt++;
      last_wr_cyc = cyc;
      if (sb_q.size() == 0) begin
        check_val("c_extra_write", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_val("c_index", bus.C_index, e.idx);
        check_val("c_data", bus.C_data_in, e.data);
      end
    end
  end

  int amat [16][16];
  int bmat [16][16];

  function automatic int cdiv(int a);
    return (a + S - 1) / S;
  endfunction

  task automatic load_mem(input int kk, input int mm, input int nn);
    for (int a = 0; a < 256; a++) begin
      a_mem[a] = '0;
      b_mem[a] = '0;
    end
    for (int t = 0; t < cdiv(mm); t++)
      for (int k = 0; k < kk; k++)
        for (int i = 0; i < S; i++)
          a_mem[t*kk+k][i*DW +: DW] = (t*S+i < mm) ? DW'(amat[t*S+i][k]) : 8'hA5;
    for (int t = 0; t < cdiv(nn); t++)
      for (int k = 0; k < kk; k++)
        for (int j = 0; j < S; j++)
          b_mem[t*kk+k][j*DW +: DW] = (t*S+j < nn) ? DW'(bmat[k][t*S+j]) : 8'h5A;
  endtask

  task automatic push_expected(input int kk, input int mm, input int nn);
    wr_t e;
    int  row, col, sum;
    if (kk == 0 || mm == 0 || nn == 0) return;
    for (int mt = 0; mt < cdiv(mm); mt++)
      for (int nt = 0; nt < cdiv(nn); nt++)
        for (int r = 0; r < S; r++) begin
          row = mt*S + r;
          if (row < mm) begin
            e.idx  = IW'(row * cdiv(nn) + nt);
            e.data = '0;
            for (int j = 0; j < S; j++) begin
              col = nt*S + j;
              sum = 0;
              if (col < nn)
                for (int k = 0; k < kk; k++) sum += amat[row][k] * bmat[k][col];
              e.data[j*AW +: AW] = AW'(sum);
            end
            sb_q.push_back(e);
          end
        end
  endtask

  task automatic rand_mats();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        amat[r][c] = int'($urandom_range(0, 15));
        bmat[r][c] = int'($urandom_range(0, 15));
      end
  endtask

  // Returns at the negedge after acceptance (the CLEAR cycle for real jobs).
  task automatic start_job(input int kk, input int mm, input int nn);
    load_mem(kk, mm, nn);
    push_expected(kk, mm, nn);
    @(negedge clk);
    K = 8'(kk); M = 8'(mm); N = 8'(nn);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_job(input string tag, input bit expect_writes);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check_val({tag, "_done_seen"}, 128'(ok), 1);
    if (expect_writes) check_val({tag, "_done_after_last_wr"}, 128'(cyc - last_wr_cyc), 1);
    check_val({tag, "_sb_empty"}, 128'(sb_q.size()), 0);
    @(negedge clk);
    check_val({tag, "_idle_after"}, busy, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_wr_en"}, bus.C_wr_en, 0);
    check_val({tag, "_clear"}, sa_clear, 0);
    check_val({tag, "_a_idx"}, bus.A_index, 0);
    check_val({tag, "_b_idx"}, bus.B_index, 0);
    check_val({tag, "_c_idx"}, bus.C_index, 0);
    check_val({tag, "_c_data"}, bus.C_data_in, 0);
    check_val({tag, "_west"}, sa_west, 0);
    check_val({tag, "_north"}, sa_north, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, n_clr, ex;
    rst_n = 1'b0; in_valid = 1'b0; K = 8'd0; M = 8'd0; N = 8'd0;
    for (int a = 0; a < 256; a++) begin a_mem[a] = '0; b_mem[a] = '0; end
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Identity 4x4: index sequence, identity rows, done latency.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        amat[r][c] = (r == c) ? 1 : 0;
        bmat[r][c] = (r == c) ? 1 : 0;
      end
    wr0 = wr_cnt;
    start_job(4, 4, 4);
    check_val("t1_busy", busy, 1);
    check_val("t1_clear", sa_clear, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("t1_a_index", bus.A_index, 128'(k));
      check_val("t1_b_index", bus.B_index, 128'(k));
    end
    finish_job("t1", 1'b1);
    check_val("t1_writes", 128'(wr_cnt - wr0), 4);

    // 5x5x5: four tiles, ragged edges.
    rand_mats();
    wr0 = wr_cnt;
    start_job(5, 5, 5);
    finish_job("t2", 1'b1);
    check_val("t2_writes", 128'(wr_cnt - wr0), 10);

    // Skew timing: word k carries k+1 on every lane.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        amat[r][c] = c + 1;
        bmat[r][c] = r + 1;
      end
    start_job(4, 4, 4);
    for (int t = 0; t < 4 + S + 2; t++) begin
      @(negedge clk);
      for (int i = 0; i < S; i++) begin
        ex = (t - 1 - i >= 0 && t - 1 - i < 4) ? (t - i) : 0;
        check_val("t3_west_lane", sa_west[i*DW +: DW], 128'(ex));
        check_val("t3_north_lane", sa_north[i*DW +: DW], 128'(ex));
      end
    end
    finish_job("t3", 1'b1);

    // K=0: immediate done, one busy cycle, no writes.
    wr0 = wr_cnt;
    start_job(0, 4, 4);
    check_val("t4_done", done, 1);
    check_val("t4_busy", busy, 1);
    @(negedge clk);
    check_val("t4_done_low", done, 0);
    check_val("t4_busy_low", busy, 0);
    check_val("t4_writes", 128'(wr_cnt - wr0), 0);

    // in_valid pulsed during FEED is ignored.
    rand_mats();
    wr0 = wr_cnt;
    start_job(4, 4, 4);
    repeat (2) @(negedge clk);
    K = 8'd2; M = 8'd8; N = 8'd8; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    finish_job("t5", 1'b1);
    check_val("t5_writes", 128'(wr_cnt - wr0), 4);

    // Non-square job with partial tiles.
    rand_mats();
    wr0 = wr_cnt;
    start_job(3, 6, 2);
    finish_job("t6", 1'b1);
    check_val("t6_writes", 128'(wr_cnt - wr0), 6);

    // Reset during FEED of the third tile, then a fresh job.
    rand_mats();
    start_job(5, 5, 5);
    n_clr = 1;
    for (int t = 0; t < 500 && n_clr < 3; t++) begin
      @(negedge clk);
      if (sa_clear === 1'b1) n_clr++;
    end
    check_val("t7_third_clear", 128'(n_clr), 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t7_rst");
    sb_q.delete();
    wr0 = wr_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("t7_no_writes", 128'(wr_cnt - wr0), 0);
    check_val("t7_idle", busy, 0);
    rand_mats();
    wr0 = wr_cnt;
    start_job(4, 4, 4);
    finish_job("t7_rerun", 1'b1);
    check_val("t7_rerun_writes", 128'(wr_cnt - wr0), 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
